eval_unit_arbiter: RTL and testbench
====================================

Name: eval_unit_arbiter

Overview:
- Shares one combinational x/y evaluation unit among NUM_REQ requesters.
- Uses round-robin arbitration, one grant per cycle at most.
- Returns a registered result tagged with the requester ID on a valid/ready response channel.
- Sits between requester agents and the shared evaluator so that one evaluator serves all agents.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of the requester ID.
- CNT_W, 16, width of the saturating evaluation counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_x  in  NUM_REQ  per-requester x operand.
- req_y  in  NUM_REQ  per-requester y operand.
- req_ready  out  NUM_REQ  one-hot or zero grant; handshake when req_valid[i]&req_ready[i].
- resp_valid  out  1  result slot holds a result.
- resp_ready  in  1  downstream accepts the result.
- resp_id  out  ID_W  requester index of the held result.
- resp_z  out  1  evaluated result.
- eval_count  out  CNT_W  total accepted requests, saturating.

Behaviour:
- Evaluation function f(x,y) = ((x^y)&x | x&y) ^ (((x^y)&x) & (x&y)).
  - Truth table: 00→0, 01→0, 10→1, 11→1.
  - It is computed by the sub-module, never inlined elsewhere.
- Output slot FSM:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
- can_accept = (state==EMPTY) | resp_ready.
- Arbitration (combinational):
  - If can_accept and any req_valid is set, grant g = first i with req_valid[i]=1, scanning from (last_ptr+1) mod NUM_REQ upward with wrap.
  - req_ready = one-hot(g). Otherwise req_ready = 0.
  - req_ready[i] never asserts while req_valid[i]=0.
- On grant (posedge):
  - resp_z ← f(req_x[g], req_y[g]), resp_id ← g, state ← FULL.
  - last_ptr ← g.
  - eval_count ← eval_count+1, saturating at all-ones.
- Latency: request handshake in cycle N → resp_valid=1 with result in cycle N+1.
- Throughput: 1 result/cycle while resp_ready=1.
- FULL & resp_ready & no grant → EMPTY.
- FULL & resp_ready & grant → stays FULL with the new result. Back-to-back transfer, no bubble.
- FULL & !resp_ready:
  - resp_valid, resp_id and resp_z are held stable.
  - req_ready = 0, so no grant.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- Pointer behaviour: last_ptr changes only on a grant. Idle cycles and back-pressure do not move it.
- Reset (synchronous, clk edge with reset=1):
  - state=EMPTY, resp_valid=0, resp_id=0, resp_z=0, eval_count=0.
  - last_ptr=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-transfer discards the held result. Requests presented during reset are not granted: req_ready=0 while reset=1.
- Requester inputs are sampled only in the grant cycle. No internal request queue.

Decomposition:
- Package eval_arb_pkg:
  - Constant DEFAULT_NUM_REQ=4.
  - typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t.
  - Function eval_fn(x,y) returning the truth table above, shared with the bench model.
- Sub-module eval_core:
  - Combinational, ports x, y, z; calls eval_fn.
  - Instantiated once in eval_unit_arbiter, fed by the muxed granted operands.
- Round-robin pick: a local function/always_comb in the top. No separate module.

Test Plan:
- Reset then idle: hold reset 2 cycles with req_valid=4'b1111 → req_ready=0, resp_valid=0, eval_count=0 during reset. First grant after release is requester 0.
- Single requester: req_valid=4'b0100, x=1, y=0, resp_ready=1 → req_ready=4'b0100 in cycle N. In cycle N+1: resp_valid=1, resp_id=2, resp_z=1.
- Round-robin, all valid, resp_ready=1, requester i drives x=i[0], y=i[1]:
  - Grants go 0,1,2,3,0.
  - resp_z sequence 0,1,0,1,0.
  - eval_count increments every cycle.
- Back-pressure:
  - Fill the slot with id=1, z=1, then hold resp_ready=0 for 3 cycles → resp_* stable, req_ready=0.
  - Raise resp_ready with req_valid[3]=1 → same-cycle grant to 3, next cycle resp_id=3, no bubble.
- Pointer persistence: grant 2, idle 3 cycles, then req_valid=4'b1101 → next grant is 3, then 0.
- Saturation and mid-op reset:
  - Force eval_count to 16'hFFFE, perform 3 grants → 16'hFFFF and it holds.
  - Assert reset while FULL → next cycle resp_valid=0, eval_count=0.

Source files
------------

// File: rtl/eval_arb_pkg.sv
// Shared types and the x/y evaluation function used by the arbiter and its evaluator core.
package eval_arb_pkg;

    localparam int unsigned DEFAULT_NUM_REQ = 4;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

    function automatic logic eval_fn(input logic x, input logic y);
        logic p;
        logic q;
        p = (x ^ y) & x;
        q = x & y;
        return (p | q) ^ (p & q);
    endfunction

endpackage

// File: rtl/eval_core.sv
// Combinational evaluator shared by all requesters through the arbiter.
module eval_core
    import eval_arb_pkg::*;
(
    input  logic x,
    input  logic y,
    output logic z
);

    assign z = eval_fn(x, y);

endmodule

// File: rtl/eval_unit_arbiter.sv
// Round-robin arbiter sharing one eval_core among NUM_REQ requesters, with a
// single registered result slot on a valid/ready response channel.
module eval_unit_arbiter
    import eval_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_x,
    input  logic [NUM_REQ-1:0] req_y,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [ID_W-1:0]    resp_id,
    output logic               resp_z,
    output logic [CNT_W-1:0]   eval_count
);

    slot_state_t        state_q, state_d;
    logic [ID_W-1:0]    last_ptr_q, last_ptr_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic               resp_z_q, resp_z_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               can_accept;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] hi_req;
    logic               core_x, core_y, core_z;

    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_REQ-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vec[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

    // Requests above last_ptr win first; otherwise wrap to the lowest valid index.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = (i > int'(last_ptr_q));
        end
        hi_req    = req_valid & hi_mask;
        grant_idx = (|hi_req) ? lowest_set(hi_req) : lowest_set(req_valid);
    end

    assign can_accept  = (state_q == SLOT_EMPTY) | resp_ready;
    assign grant_valid = can_accept & (|req_valid) & ~reset;
    assign req_ready   = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;

    assign core_x = req_x[grant_idx];
    assign core_y = req_y[grant_idx];

    eval_core u_eval_core (
        .x (core_x),
        .y (core_y),
        .z (core_z)
    );

    always_comb begin
        state_d    = state_q;
        last_ptr_d = last_ptr_q;
        resp_id_d  = resp_id_q;
        resp_z_d   = resp_z_q;
        cnt_d      = cnt_q;
        if (grant_valid) begin
            state_d    = SLOT_FULL;
            last_ptr_d = grant_idx;
            resp_id_d  = grant_idx;
            resp_z_d   = core_z;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if ((state_q == SLOT_FULL) && resp_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SLOT_EMPTY;
            last_ptr_q <= ID_W'(NUM_REQ - 1);
            resp_id_q  <= '0;
            resp_z_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            resp_id_q  <= resp_id_d;
            resp_z_q   <= resp_z_d;
            cnt_q      <= cnt_d;
        end
    end

    assign resp_valid = (state_q == SLOT_FULL);
    assign resp_id    = resp_id_q;
    assign resp_z     = resp_z_q;
    assign eval_count = cnt_q;

endmodule

// File: tb/tb_eval_unit_arbiter.sv
// Self-checking bench for eval_unit_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin reference model.
module tb_eval_unit_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_x;
    logic [N-1:0] req_y;
    logic [N-1:0] req_ready;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_id;
    logic         resp_z;
    logic [15:0]  eval_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_full;
    bit m_z;
    int m_id;
    int m_ptr;
    int m_cnt;
    bit tt [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    eval_unit_arbiter #(
        .NUM_REQ (N),
        .ID_W    (2),
        .CNT_W   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_z     (resp_z),
        .eval_count (eval_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_pick();
        if (reset) return -1;
        if (m_full && !resp_ready) return -1;
        for (int k = 1; k <= N; k++) begin
            int i = (m_ptr + k) % N;
            if (req_valid[i[1:0]]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int g = m_pick();
        return (g >= 0) ? (4'b0001 << g[1:0]) : 4'b0000;
    endfunction

    // Advance one clock, updating the model with the inputs seen at the edge.
    task automatic tick();
        int g;
        bit rst, rr, xv, yv;
        g   = m_pick();
        rst = reset;
        rr  = resp_ready;
        xv  = (g >= 0) ? req_x[g[1:0]] : 1'b0;
        yv  = (g >= 0) ? req_y[g[1:0]] : 1'b0;
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_id = 0; m_z = 0; m_ptr = N - 1; m_cnt = 0;
        end else if (g >= 0) begin
            m_full = 1; m_id = g; m_z = tt[{xv, yv}]; m_ptr = g;
            if (m_cnt < 65535) m_cnt++;
        end else if (m_full && rr) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 4'b1111; req_x = '0; req_y = '0; resp_ready = 1'b1;
        repeat (2) begin
            tick();
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
            end
            n_checks++;
            if (resp_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_valid: got %b expected 0", resp_valid);
            end
            n_checks++;
            if (eval_count !== 16'h0) begin
                n_fail++; $display("FAIL reset_count: got %h expected 0000", eval_count);
            end
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
        end
        tick();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0) begin
            n_fail++; $display("FAIL reset_first_resp: got v=%b id=%0d expected v=1 id=0",
                               resp_valid, resp_id);
        end
    endtask

    task automatic test_single();
        req_valid = '0; resp_ready = 1'b1;
        tick();
        req_valid = 4'b0100; req_x = 4'b0100; req_y = 4'b0000;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_ready: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_z !== 1'b1) begin
            n_fail++; $display("FAIL single_resp: got v=%b id=%0d z=%b expected v=1 id=2 z=1",
                               resp_valid, resp_id, resp_z);
        end
    endtask

    task automatic test_round_robin();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        int exp_z [5] = '{0, 1, 0, 1, 0};
        do_reset();
        req_valid = 4'b1111; req_x = 4'b1010; req_y = 4'b1100; resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (req_ready !== (4'b0001 << exp_g[k])) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b expected id %0d", k, req_ready,
                                   exp_g[k]);
            end
            tick();
            n_checks++;
            if (resp_id !== 2'(exp_g[k]) || resp_z !== 1'(exp_z[k]) ||
                eval_count !== 16'(k + 1)) begin
                n_fail++;
                $display("FAIL rr_resp[%0d]: got id=%0d z=%b cnt=%0d expected id=%0d z=%0d cnt=%0d",
                         k, resp_id, resp_z, eval_count, exp_g[k], exp_z[k], k + 1);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_back_pressure();
        do_reset();
        req_valid = 4'b0010; req_x = 4'b0010; req_y = 4'b0000; resp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_fill: got %b expected 0010", req_ready);
        end
        tick();
        req_valid = 4'b1111; resp_ready = 1'b0;
        repeat (3) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_id !== 2'd1 ||
                resp_z !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold: got rdy=%b v=%b id=%0d z=%b expected rdy=0000 v=1 id=1 z=1",
                         req_ready, resp_valid, resp_id, resp_z);
            end
            tick();
        end
        resp_ready = 1'b1; req_valid = 4'b1000; req_x = 4'b0000;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000 || resp_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got rdy=%b v=%b expected rdy=1000 v=1",
                               req_ready, resp_valid);
        end
        tick();
        req_valid = '0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_z !== 1'b0) begin
            n_fail++; $display("FAIL bp_next: got v=%b id=%0d z=%b expected v=1 id=3 z=0",
                               resp_valid, resp_id, resp_z);
        end
        tick();
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got v=%b expected 0", resp_valid);
        end
    endtask

    task automatic test_pointer();
        do_reset();
        resp_ready = 1'b1; req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (3) tick();
        req_valid = 4'b1101;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL ptr_first: got %b expected 1000", req_ready);
        end
        tick();
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL ptr_second: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid  = 4'($urandom);
            req_x      = 4'($urandom);
            req_y      = 4'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 49) == 0);
            #1;
            n_checks++;
            if (req_ready !== m_ready()) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready,
                                   m_ready());
            end
            n_checks++;
            if (resp_valid !== m_full || (m_full && (resp_id !== 2'(m_id) || resp_z !== m_z)) ||
                eval_count !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: got v=%b id=%0d z=%b cnt=%0d expected v=%b id=%0d z=%b cnt=%0d",
                         c, resp_valid, resp_id, resp_z, eval_count, m_full, m_id, m_z, m_cnt);
            end
            tick();
        end
        reset = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_saturation();
        do_reset();
        req_valid = 4'b1111; resp_ready = 1'b1;
        repeat (65534) tick();
        n_checks++;
        if (eval_count !== 16'hFFFE) begin
            n_fail++; $display("FAIL sat_pre: got %h expected fffe", eval_count);
        end
        repeat (3) begin
            tick();
            n_checks++;
            if (eval_count !== 16'hFFFF) begin
                n_fail++; $display("FAIL sat_hold: got %h expected ffff", eval_count);
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL midreset_ready: got %b expected 0000", req_ready);
        end
        tick();
        reset = 1'b0; req_valid = '0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || eval_count !== 16'h0) begin
            n_fail++; $display("FAIL midreset_state: got v=%b cnt=%h expected v=0 cnt=0000",
                               resp_valid, eval_count);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_x = '0; req_y = '0; resp_ready = 1'b1;
        m_full = 0; m_z = 0; m_id = 0; m_ptr = N - 1; m_cnt = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_pointer();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
